// File: rtl/control_contador.sv
// Sweep sequencer for an 8-bit up/down counter: ramps between latched limits,
// dwells at each end, repeats for a programmed number of sweeps.
module control_contador #(
  parameter int WIDTH   = 8,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [WIDTH-1:0]   lim_lo,
  input  logic [WIDTH-1:0]   lim_hi,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [7:0]         cycles,
  input  logic [WIDTH-1:0]   cnt_in,
  output logic               act,
  output logic               updown,
  output logic               cnt_clr,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [7:0]         sweep_cnt
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CLEAR    = 3'd1;
  localparam logic [2:0] SEEK     = 3'd2;
  localparam logic [2:0] UP       = 3'd3;
  localparam logic [2:0] DWELL_HI = 3'd4;
  localparam logic [2:0] DOWN     = 3'd5;
  localparam logic [2:0] DWELL_LO = 3'd6;
  localparam logic [2:0] DONE     = 3'd7;

  logic [2:0]         state_reg, state_next;
  logic [WIDTH-1:0]   lo_reg, hi_reg;
  logic [DWELL_W-1:0] dwell_reg, dwell_cnt_reg;
  logic [7:0]         cycles_reg, sweep_reg;
  logic               latch, load_dwell, bump_sweep, err_next;
  logic [WIDTH-1:0]   lo_m1, lo_p1, hi_m1;
  logic [7:0]         sweep_inc;

  // Exit compares look one step ahead so the counter lands exactly on the limit.
  assign lo_m1     = lo_reg - 1'b1;
  assign lo_p1     = lo_reg + 1'b1;
  assign hi_m1     = hi_reg - 1'b1;
  assign sweep_inc = sweep_reg + 8'd1;

  always_comb begin
    state_next = state_reg;
    latch      = 1'b0;
    load_dwell = 1'b0;
    bump_sweep = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && !stop) begin
          if (lim_hi > lim_lo) begin
            latch      = 1'b1;
            state_next = CLEAR;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      CLEAR:    state_next = (lo_reg != '0) ? SEEK : UP;
      SEEK:     if (cnt_in == lo_m1) state_next = UP;
      UP: begin
        if (cnt_in == hi_m1) begin
          state_next = DWELL_HI;
          load_dwell = 1'b1;
        end
      end
      DWELL_HI: if (dwell_cnt_reg == '0) state_next = DOWN;
      DOWN: begin
        if (cnt_in == lo_p1) begin
          state_next = DWELL_LO;
          load_dwell = 1'b1;
        end
      end
      DWELL_LO: begin
        if (dwell_cnt_reg == '0) begin
          bump_sweep = 1'b1;
          state_next = (cycles_reg != 8'd0 && sweep_inc == cycles_reg) ? DONE : UP;
        end
      end
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    // Abort overrides everything and leaves the sweep count untouched.
    if (state_reg != IDLE && stop) begin
      state_next = IDLE;
      load_dwell = 1'b0;
      bump_sweep = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      lo_reg        <= '0;
      hi_reg        <= '0;
      dwell_reg     <= '0;
      cycles_reg    <= 8'd0;
      dwell_cnt_reg <= '0;
      sweep_reg     <= 8'd0;
    end else begin
      state_reg <= state_next;
      if (latch) begin
        lo_reg     <= lim_lo;
        hi_reg     <= lim_hi;
        dwell_reg  <= dwell;
        cycles_reg <= cycles;
        sweep_reg  <= 8'd0;
      end else if (bump_sweep) begin
        sweep_reg <= sweep_inc;
      end
      if (load_dwell)
        dwell_cnt_reg <= dwell_reg;
      else if (dwell_cnt_reg != '0)
        dwell_cnt_reg <= dwell_cnt_reg - 1'b1;
    end
  end

  // Outputs are registered from the next state so they line up with state_reg.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act     <= 1'b0;
      updown  <= 1'b0;
      cnt_clr <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      act     <= (state_next == SEEK) || (state_next == UP) || (state_next == DOWN);
      updown  <= (state_next != IDLE) && (state_next != DOWN);
      cnt_clr <= (state_next == CLEAR);
      busy    <= (state_next != IDLE);
      done    <= (state_next == DONE);
      err     <= err_next;
    end
  end

  assign sweep_cnt = sweep_reg;

endmodule

// File: tb/tb_control_contador.sv
// Bench for control_contador: a behavioural counter plus an expected per-cycle
// trace built from limit/dwell/sweep arithmetic.
module tb_control_contador;

  logic       clk = 1'b0;
  logic       reset, start, stop;
  logic [7:0] lim_lo, lim_hi, cycles, cnt_in;
  logic [3:0] dwell;
  logic       act, updown, cnt_clr, busy, done, err;
  logic [7:0] sweep_cnt;

  int n_pass  = 0;
  int n_total = 0;

  localparam int P_CLR = 0, P_SEEK = 1, P_UP = 2, P_DH = 3, P_DN = 4, P_DL = 5,
                 P_DONE = 6, P_IDLE = 7;

  typedef struct {
    int ph;
    int cnt;
    bit cnt_ok;
    int sw;
  } exp_t;

  exp_t q[$];

  control_contador #(.WIDTH(8), .DWELL_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .lim_lo(lim_lo), .lim_hi(lim_hi), .dwell(dwell), .cycles(cycles),
    .cnt_in(cnt_in), .act(act), .updown(updown), .cnt_clr(cnt_clr),
    .busy(busy), .done(done), .err(err), .sweep_cnt(sweep_cnt)
  );

  always #5 clk = ~clk;

  // Stand-in for the counter, cleared by reset | cnt_clr.
  always @(posedge clk or posedge reset) begin
    if (reset)        cnt_in <= 8'd0;
    else if (cnt_clr) cnt_in <= 8'd0;
    else if (act)     cnt_in <= updown ? cnt_in + 8'd1 : cnt_in - 8'd1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
  endtask

  function automatic void push(int ph, int cnt, bit cnt_ok, int sw);
    exp_t e;
    e.ph = ph; e.cnt = cnt; e.cnt_ok = cnt_ok; e.sw = sw;
    q.push_back(e);
  endfunction

  // Expected trace: CLEAR, lo cycles of SEEK, then per sweep (hi-lo) up,
  // dwell+1 high, (hi-lo) down, dwell+1 low, then DONE and IDLE.
  function automatic void build(int lo, int hi, int dw, int cy, int nsw);
    q.delete();
    push(P_CLR, 0, 0, 0);
    for (int i = 0; i < lo; i++) push(P_SEEK, i, 1, 0);
    for (int s = 0; s < nsw; s++) begin
      for (int i = 0; i < hi - lo; i++) push(P_UP, lo + i, 1, s);
      for (int i = 0; i <= dw; i++)     push(P_DH, hi, 1, s);
      for (int i = 0; i < hi - lo; i++) push(P_DN, hi - i, 1, s);
      for (int i = 0; i <= dw; i++)     push(P_DL, lo, 1, s);
    end
    if (cy != 0) begin
      push(P_DONE, lo, 1, cy % 256);
      push(P_IDLE, lo, 1, cy % 256);
    end
  endfunction

  task automatic check_entry(input exp_t e);
    bit run_act;
    run_act = (e.ph == P_SEEK) || (e.ph == P_UP) || (e.ph == P_DN);
    chk("act", act, run_act);
    chk("cnt_clr", cnt_clr, e.ph == P_CLR);
    chk("busy", busy, e.ph != P_IDLE);
    chk("done", done, e.ph == P_DONE);
    chk("err", err, 0);
    if (e.ph != P_IDLE) chk("updown", updown, e.ph != P_DN);
    if (e.cnt_ok) chk("cnt_in", cnt_in, e.cnt);
    chk("sweep_cnt", sweep_cnt, e.sw);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_act"}, act, 0);
    chk({tag, "_updown"}, updown, 0);
    chk({tag, "_clr"}, cnt_clr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_sweep"}, sweep_cnt, 0);
  endtask

  // mode 0: plain run; 1: stop during 2nd down-step of sweep 1;
  // 2: async reset inside first high dwell; 3: extra start during UP.
  task automatic run(input int lo, input int hi, input int dw, input int cy,
                     input int nsw, input int mode);
    int  seen_dn;
    bit  poked;
    int  frozen;
    seen_dn = 0;
    poked   = 0;
    lim_lo = lo[7:0]; lim_hi = hi[7:0]; dwell = dw[3:0]; cycles = cy[7:0];
    start = 1'b1;
    build(lo, hi, dw, cy, nsw);
    tick;
    start = 1'b0;
    // Limits must have been latched; scramble the inputs.
    lim_lo = 8'($urandom); lim_hi = 8'($urandom);
    dwell = 4'($urandom); cycles = 8'($urandom);
    $display("run lo=%0d hi=%0d dwell=%0d cycles=%0d mode=%0d", lo, hi, dw, cy, mode);
    foreach (q[i]) begin
      check_entry(q[i]);
      if (mode == 1 && q[i].ph == P_DN && q[i].sw == 1) begin
        seen_dn++;
        if (seen_dn == 2) begin
          stop = 1'b1;
          tick;
          stop = 1'b0;
          frozen = q[i].cnt - 1;
          for (int k = 0; k < 3; k++) begin
            chk("stop_act", act, 0);
            chk("stop_busy", busy, 0);
            chk("stop_done", done, 0);
            chk("stop_cnt", cnt_in, frozen);
            chk("stop_sweep", sweep_cnt, 1);
            tick;
          end
          return;
        end
      end
      if (mode == 2 && q[i].ph == P_DH) begin
        #2 reset = 1'b1;
        #1;
        check_zero("rst");
        chk("rst_cnt", cnt_in, 0);
        reset = 1'b0;
        tick;
        chk("rst_idle_busy", busy, 0);
        return;
      end
      if (mode == 3 && q[i].ph == P_UP && !poked) begin
        poked  = 1;
        start  = 1'b1;
        lim_lo = 8'd0;
        lim_hi = 8'd200;
      end
      if (i < q.size() - 1) tick;
      start = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    lim_lo = 8'd0; lim_hi = 8'd0; dwell = 4'd0; cycles = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;
    tick;
    check_zero("post_reset");

    run(2, 5, 1, 1, 1, 0);
    run(0, 1, 0, 3, 3, 0);

    // Rejected starts: equal limits, then inverted limits.
    lim_lo = 8'd4; lim_hi = 8'd4; start = 1'b1;
    tick;
    start = 1'b0;
    chk("rej_err", err, 1); chk("rej_busy", busy, 0); chk("rej_act", act, 0);
    tick;
    chk("rej_err_clr", err, 0); chk("rej_busy2", busy, 0); chk("rej_act2", act, 0);
    lim_lo = 8'd9; lim_hi = 8'd3; start = 1'b1;
    tick;
    start = 1'b0;
    chk("rej2_err", err, 1); chk("rej2_busy", busy, 0);
    $display("rejected starts checked");

    // start and stop together in IDLE.
    lim_lo = 8'd1; lim_hi = 8'd5; start = 1'b1; stop = 1'b1;
    tick;
    start = 1'b0; stop = 1'b0;
    chk("ss_err", err, 0); chk("ss_busy", busy, 0); chk("ss_clr", cnt_clr, 0);
    tick;
    chk("ss_busy2", busy, 0); chk("ss_act", act, 0);
    $display("start+stop in idle checked");

    run(1, 4, 0, 0, 2, 1);
    run(3, 7, 2, 2, 2, 3);
    run(1, 6, 3, 2, 2, 2);
    run(2, 5, 1, 1, 1, 0);

    for (int r = 0; r < 15; r++) begin
      int lo, hi, dw, cy;
      lo = $urandom_range(0, 6);
      hi = lo + $urandom_range(1, 5);
      dw = $urandom_range(0, 3);
      cy = $urandom_range(1, 3);
      run(lo, hi, dw, cy, cy, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
